// File: rtl/jpeg_zz_pkg.sv
// Shared definitions for the JPEG zigzag reorder block: bank state
// encoding, block size and the zigzag scan table (zigzag index -> raster index).
package jpeg_zz_pkg;

   localparam int BLK_SIZE = 64;

   localparam logic [5:0] LAST_IDX = 6'd63;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   // Entry k is the raster index (8*v + u) of the k-th coefficient in zigzag order.
   localparam logic [5:0] ZZ_ORDER [BLK_SIZE] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/jpeg_zz_bank.sv
// One 64-entry coefficient bank: synchronous write, asynchronous read.
// Contents are deliberately not reset; bank state in the top level
// decides whether an entry is meaningful.
module jpeg_zz_bank
   import jpeg_zz_pkg::*;
#(
   parameter int DW = 12
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [5:0]           waddr,
   input  logic signed [DW-1:0] wdata,
   input  logic [5:0]           raddr,
   output logic signed [DW-1:0] rdata
);

   logic signed [DW-1:0] mem [BLK_SIZE];

   // Store one raster-order coefficient per accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/jpeg_zigzag_reorder.sv
// JPEG zigzag reorder: accepts 8x8 DCT blocks in raster order and re-emits
// them in zigzag order through a ping-pong pair of banks and a one-entry
// registered output stage.
// Optional feature macro: JPEG_ZZ_NZCNT_EN adds per-block nonzero counting
// and the dout_nz_cnt output port.
module jpeg_zigzag_reorder
   import jpeg_zz_pkg::*;
#(
   parameter int DW   = 12,
   parameter int NBLK = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   output logic                 din_ready,
   input  logic signed [DW-1:0] din,
   output logic                 dout_valid,
   input  logic                 dout_ready,
   output logic signed [DW-1:0] dout,
   output logic                 dout_last
`ifdef JPEG_ZZ_NZCNT_EN
   ,
   output logic [6:0]           dout_nz_cnt
`endif
);

   if (NBLK != 2) begin : g_nblk_check
      $error("jpeg_zigzag_reorder: NBLK must be 2");
   end

   bank_state_t          state     [2];
   bank_state_t          state_nxt [2];
   logic                 wr_bank;
   logic                 rd_bank;
   logic [5:0]           wr_idx;
   logic [5:0]           rd_idx;
   // All 64 reads of rd_bank have been issued; only dout_last is still pending.
   logic                 rd_all_issued;

   logic                 wr_fire;
   logic                 wr_open;
   logic                 wr_recycle;
   logic                 stage_free;
   logic                 last_xfer;
   logic                 cur_avail;
   logic                 nxt_avail;
   logic                 load;
   logic                 rd_sel;
   logic [1:0]           bank_we;
   logic [5:0]           raddr;
   logic signed [DW-1:0] bank_rdata [2];

   // Write side may proceed into an open bank, or into the bank whose final
   // output leaves on this very edge (its reads are all done), so streaming
   // input never stalls between blocks.
   assign wr_open    = (state[wr_bank] == EMPTY) || (state[wr_bank] == FILLING);
   assign last_xfer  = dout_valid && dout_ready && dout_last;
   assign wr_recycle = (wr_bank == rd_bank) && last_xfer;
   assign din_ready  = wr_open || wr_recycle;
   assign wr_fire    = din_valid && din_ready;

   // Read side: continue the current bank, or hop to the other bank on the
   // edge that transfers the last output so consecutive blocks are gap-free.
   assign stage_free = !dout_valid || dout_ready;
   assign cur_avail  = (state[rd_bank] == FULL) ||
                       ((state[rd_bank] == DRAINING) && !rd_all_issued);
   assign nxt_avail  = rd_all_issued && last_xfer && (state[~rd_bank] == FULL);
   assign load       = stage_free && (cur_avail || nxt_avail);
   assign rd_sel     = cur_avail ? rd_bank : ~rd_bank;
   assign raddr      = ZZ_ORDER[rd_idx];

   assign bank_we[0] = wr_fire && !wr_bank;
   assign bank_we[1] = wr_fire &&  wr_bank;

   for (genvar g = 0; g < 2; g++) begin : g_bank
      jpeg_zz_bank #(
         .DW (DW)
      ) u_bank (
         .clk   (clk),
         .we    (bank_we[g]),
         .waddr (wr_idx),
         .wdata (din),
         .raddr (raddr),
         .rdata (bank_rdata[g])
      );
   end

   // Next bank states; the write update is applied last so a bank that is
   // freed and refilled on the same edge ends up FILLING.
   always_comb begin
      state_nxt[0] = state[0];
      state_nxt[1] = state[1];
      if (last_xfer) begin
         state_nxt[rd_bank] = EMPTY;
      end
      if (load) begin
         state_nxt[rd_sel] = DRAINING;
      end
      if (wr_fire) begin
         state_nxt[wr_bank] = (wr_idx == LAST_IDX) ? FULL : FILLING;
      end
   end

   // Bank states and write/read pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state[0]      <= EMPTY;
         state[1]      <= EMPTY;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         wr_idx        <= 6'd0;
         rd_idx        <= 6'd0;
         rd_all_issued <= 1'b0;
      end else begin
         state[0] <= state_nxt[0];
         state[1] <= state_nxt[1];
         if (wr_fire) begin
            wr_idx <= wr_idx + 6'd1;
            if (wr_idx == LAST_IDX) begin
               wr_bank <= ~wr_bank;
            end
         end
         if (last_xfer) begin
            rd_bank <= ~rd_bank;
         end
         if (load) begin
            rd_idx        <= rd_idx + 6'd1;
            rd_all_issued <= (rd_idx == LAST_IDX);
         end else if (last_xfer) begin
            rd_all_issued <= 1'b0;
         end
      end
   end

   // One-entry registered output stage; holds its contents under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout       <= '0;
         dout_last  <= 1'b0;
      end else if (load) begin
         dout_valid <= 1'b1;
         dout       <= bank_rdata[rd_sel];
         dout_last  <= (rd_idx == LAST_IDX);
      end else if (dout_valid && dout_ready) begin
         dout_valid <= 1'b0;
      end
   end

`ifdef JPEG_ZZ_NZCNT_EN
   logic [6:0] nz_cnt [2];
   logic [6:0] nz_base;
   logic [6:0] nz_inc;

   // The first write of a block starts from zero, which also covers a bank
   // that is cleared and refilled on the same edge.
   assign nz_base = (wr_idx == 6'd0) ? 7'd0 : nz_cnt[wr_bank];
   assign nz_inc  = {6'd0, (din != '0)};

   // Per-bank nonzero counters and the count presented with each output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nz_cnt[0]   <= 7'd0;
         nz_cnt[1]   <= 7'd0;
         dout_nz_cnt <= 7'd0;
      end else begin
         if (last_xfer) begin
            nz_cnt[rd_bank] <= 7'd0;
         end
         if (wr_fire) begin
            nz_cnt[wr_bank] <= nz_base + nz_inc;
         end
         if (load) begin
            dout_nz_cnt <= nz_cnt[rd_sel];
         end
      end
   end
`endif

endmodule

// File: tb/tb_jpeg_zigzag_reorder.sv
// Directed bench for jpeg_zigzag_reorder: streams raster blocks, compares
// the zigzag output against a bench-built scan order, and checks flow control.
`timescale 1ns/1ps
module tb_jpeg_zigzag_reorder;

   localparam int DW = 12;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 din_valid;
   logic                 din_ready;
   logic signed [DW-1:0] din;
   logic                 dout_valid;
   logic                 dout_ready;
   logic signed [DW-1:0] dout;
   logic                 dout_last;
`ifdef JPEG_ZZ_NZCNT_EN
   logic [6:0]           dout_nz_cnt;
`endif

   int checks = 0;
   int errors = 0;

   int                   zz_tb [64];
   logic signed [DW-1:0] blk   [64];
   logic signed [DW-1:0] in_q  [$];
   logic signed [DW-1:0] exp_q [$];
   logic                 exp_last_q [$];
   int                   exp_nz_q [$];
   logic signed [DW-1:0] out_log [$];
   int gaps, rdy_low, first_v, acc64;

   always #5 clk = ~clk;

   jpeg_zigzag_reorder #(.DW(DW), .NBLK(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din        (din),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_last  (dout_last)
`ifdef JPEG_ZZ_NZCNT_EN
      ,
      .dout_nz_cnt(dout_nz_cnt)
`endif
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Zigzag scan built by walking anti-diagonals s = u + v.
   function automatic void build_zz();
      int k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo = (s > 7) ? s - 7 : 0;
         int hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int v = hi; v >= lo; v--) begin zz_tb[k] = 8 * v + (s - v); k++; end
         end else begin
            for (int v = lo; v <= hi; v++) begin zz_tb[k] = 8 * v + (s - v); k++; end
         end
      end
   endfunction

   function automatic void push_block(input bit feed);
      int nz = 0;
      for (int i = 0; i < 64; i++) begin
         if (blk[i] != 0) nz++;
         if (feed) in_q.push_back(blk[i]);
      end
      for (int k = 0; k < 64; k++) begin
         exp_q.push_back(blk[zz_tb[k]]);
         exp_last_q.push_back(k == 63);
         exp_nz_q.push_back(nz);
      end
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      din_valid = 1'b0;
      din = '0;
      dout_ready = 1'b0;
      in_q.delete(); exp_q.delete(); exp_last_q.delete(); exp_nz_q.delete(); out_log.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic run(input int vld_pct, input int rdy_pct, input int budget, input string tag);
      int cyc = 0;
      int acc = 0;
      logic signed [DW-1:0] e;
      logic l;
      int enz;
      gaps = 0; rdy_low = 0; first_v = -1; acc64 = -1;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(negedge clk);
         din_valid  = (in_q.size() > 0) && ($urandom_range(99) < vld_pct);
         din        = din_valid ? in_q[0] : '0;
         dout_ready = ($urandom_range(99) < rdy_pct);
         #1;
         if (din_valid && din_ready) begin
            void'(in_q.pop_front());
            acc++;
            if (acc == 64) acc64 = cyc;
         end else if (din_valid) begin
            rdy_low++;
         end
         if (dout_valid) begin
            if (first_v < 0) first_v = cyc;
         end else if (first_v >= 0 && exp_q.size() > 0) begin
            gaps++;
         end
         if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_output"}, 32'(dout), 32'(0));
            end else begin
               e = exp_q.pop_front();
               l = exp_last_q.pop_front();
               enz = exp_nz_q.pop_front();
               check({tag, "_dout"}, 32'(dout), 32'(e));
               check({tag, "_dout_last"}, 32'(dout_last), 32'(l));
`ifdef JPEG_ZZ_NZCNT_EN
               check({tag, "_dout_nz_cnt"}, 32'(dout_nz_cnt), 32'(enz));
`endif
               out_log.push_back(dout);
            end
         end
         cyc++;
      end
      @(negedge clk);
      din_valid = 1'b0;
      din = '0;
      dout_ready = 1'b0;
      check({tag, "_all_done_in_budget"}, 32'(in_q.size() + exp_q.size()), 32'(0));
   endtask

   initial begin
      int acc;
      int changes;
      logic signed [DW-1:0] held;
      build_zz();

      // Test 1: reset state and a single ramp block
      do_reset();
      check("rst_din_ready", 32'(din_ready), 32'(1));
      check("rst_dout_valid", 32'(dout_valid), 32'(0));
      check("rst_dout", 32'(dout), 32'(0));
      check("rst_dout_last", 32'(dout_last), 32'(0));
      for (int i = 0; i < 64; i++) blk[i] = DW'(i);
      push_block(1'b1);
      run(100, 100, 400, "t1");
      check("t1_out2", 32'(out_log[2]), 32'(8));
      check("t1_out3", 32'(out_log[3]), 32'(16));
      check("t1_out9", 32'(out_log[9]), 32'(24));
      check("t1_out61", 32'(out_log[61]), 32'(55));
      check("t1_out62", 32'(out_log[62]), 32'(62));
      check("t1_out63", 32'(out_log[63]), 32'(63));
      check("t1_latency", 32'(first_v - acc64), 32'(2));
      check("t1_idle_after", 32'(dout_valid), 32'(0));

      // Test 2: three blocks back-to-back
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 64; i++) blk[i] = DW'(64 * b + i);
         push_block(1'b1);
      end
      run(100, 100, 600, "t2");
      check("t2_dout_gaps", 32'(gaps), 32'(0));
      check("t2_din_ready_low", 32'(rdy_low), 32'(0));

      // Test 3: consumer stalled while 130 inputs are offered
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 64; i++) blk[i] = DW'(64 * b + i);
         push_block(1'b1);
      end
      in_q.push_back(DW'(7));
      in_q.push_back(DW'(9));
      acc = 0; changes = 0; held = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         dout_ready = 1'b0;
         din_valid  = (in_q.size() > 0);
         din        = din_valid ? in_q[0] : '0;
         #1;
         if (din_valid && din_ready) begin
            void'(in_q.pop_front());
            acc++;
         end
         if (dout_valid) begin
            if (dout !== held) changes++;
         end
      end
      check("t3_accepted", 32'(acc), 32'(128));
      check("t3_din_ready_low", 32'(din_ready), 32'(0));
      check("t3_dout_valid_held", 32'(dout_valid), 32'(1));
      check("t3_dout_held_value", 32'(dout), 32'(0));
      check("t3_dout_changes", 32'(changes), 32'(0));
      in_q.delete();
      run(0, 100, 400, "t3_drain");

      // Test 4: random gaps on both sides over 20 blocks
      do_reset();
      for (int b = 0; b < 20; b++) begin
         for (int i = 0; i < 64; i++) blk[i] = DW'($urandom_range(0, 4095));
         push_block(1'b1);
      end
      run(70, 50, 20000, "t4");

      // Test 5: reset pulsed after 30 inputs, then a fresh block
      do_reset();
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         dout_ready = 1'b1;
         din_valid  = 1'b1;
         din        = DW'(1000 + c);
      end
      @(negedge clk);
      din_valid = 1'b0;
      rst = 1'b1;
      #2;
      check("t5_rst_dout_valid", 32'(dout_valid), 32'(0));
      rst = 1'b0;
      #1;
      check("t5_rst_din_ready", 32'(din_ready), 32'(1));
      for (int i = 0; i < 64; i++) blk[i] = DW'(300 + i);
      push_block(1'b1);
      run(100, 100, 400, "t5");
      check("t5_first_out", 32'(out_log[0]), 32'(300));
      check("t5_output_count", 32'(out_log.size()), 32'(64));

`ifdef JPEG_ZZ_NZCNT_EN
      // Test 6: nonzero counting
      do_reset();
      for (int i = 0; i < 64; i++) blk[i] = '0;
      blk[0] = DW'(5); blk[1] = -DW'(3); blk[63] = DW'(7);
      push_block(1'b1);
      for (int i = 0; i < 64; i++) blk[i] = '0;
      push_block(1'b1);
      run(100, 100, 600, "t6");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
